parity_mem_ctrl: RTL and testbench

PARITY_MEM_CTRL -- requirements
Module: parity_mem_ctrl

---
 rtl/parity_mem_ctrl.sv | 90 +++++++++
 tb/tb_parity_mem_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/parity_mem_ctrl.sv
// Single-port word memory with one parity bit per word, written-flags and a saturating
// parity-error counter. Reads return one cycle later; a write wins over a same-cycle read.
module parity_mem_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_err,
  input  logic              clr_cnt,
  output logic [DATA_W:0]   data_out,
  output logic              rd_valid,
  output logic              par_err,
  output logic              uninit,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W:0]    mem [Depth];
  logic [Depth-1:0]   written_q;

  logic [DATA_W:0]    data_out_q;
  logic               rd_valid_q;
  logic               par_err_q;
  logic               uninit_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic               rd_accept;
  logic               wr_parity;
  logic [DATA_W:0]    rd_word;
  logic               rd_written;
  logic               rd_bad;

  assign rd_accept  = read & ~write;
  assign wr_parity  = (^data_in) ^ inj_err;
  assign rd_word    = mem[address];
  assign rd_written = written_q[address];
  // Only a previously written word can report a parity error.
  assign rd_bad     = rd_accept & rd_written & (^rd_word);

  // Payload array carries no reset; validity comes from written_q.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[address] <= {wr_parity, data_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (write) begin
      written_q[address] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      uninit_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      par_err_q  <= rd_bad;
      uninit_q   <= rd_accept & ~rd_written;
      if (rd_accept) begin
        data_out_q <= rd_written ? rd_word : '0;
      end
      if (clr_cnt) begin
        err_cnt_q <= '0;
      end else if (rd_bad && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign par_err  = par_err_q;
  assign uninit   = uninit_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_parity_mem_ctrl.sv
// Table-driven bench for parity_mem_ctrl (CNT_W=2 so counter saturation is reachable),
// plus a hand-written asynchronous-reset-mid-read sequence.
module tb_parity_mem_ctrl;

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 8;
  localparam int unsigned CntW  = 2;

  logic             clk;
  logic             rst_n;
  logic             write;
  logic             read;
  logic [AddrW-1:0] address;
  logic [DataW-1:0] data_in;
  logic             inj_err;
  logic             clr_cnt;
  logic [DataW:0]   data_out;
  logic             rd_valid;
  logic             par_err;
  logic             uninit;
  logic [CntW-1:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  parity_mem_ctrl #(
    .DATA_W(DataW),
    .ADDR_W(AddrW),
    .CNT_W (CntW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .write   (write),
    .read    (read),
    .address (address),
    .data_in (data_in),
    .inj_err (inj_err),
    .clr_cnt (clr_cnt),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .par_err (par_err),
    .uninit  (uninit),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             wr;
    logic             rd;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] din;
    logic             inj;
    logic             clr;
    logic             e_valid;
    logic [DataW:0]   e_dout;
    logic             e_perr;
    logic             e_uninit;
    logic [CntW-1:0]  e_cnt;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] addr,
                              input logic [7:0] din, input logic inj, input logic clr,
                              input logic ev, input logic [8:0] ed, input logic ep,
                              input logic eu, input logic [1:0] ec);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.din = din; v.inj = inj; v.clr = clr;
    v.e_valid = ev; v.e_dout = ed; v.e_perr = ep; v.e_uninit = eu; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [AddrW-1:0] addr,
                       input logic [DataW-1:0] din, input logic inj, input logic clr);
    @(negedge clk);
    write = wr; read = rd; address = addr; data_in = din; inj_err = inj; clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [DataW:0] ed,
                            input logic ep, input logic eu, input logic [CntW-1:0] ec);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(ev));
    check({tag, ".data_out"}, 32'(data_out), 32'(ed));
    check({tag, ".par_err"},  32'(par_err),  32'(ep));
    check({tag, ".uninit"},   32'(uninit),   32'(eu));
    check({tag, ".err_cnt"},  32'(err_cnt),  32'(ec));
  endtask

  initial begin
    //               wr rd addr   din    inj clr  v  dout    p  u  cnt
    vecs[0]  = mk(1, 0, 8'h10, 8'h07, 0, 0, 0, 9'h000, 0, 0, 2'd0);
    vecs[1]  = mk(0, 1, 8'h10, 8'h00, 0, 0, 1, 9'h107, 0, 0, 2'd0);
    vecs[2]  = mk(1, 0, 8'h11, 8'h03, 1, 0, 0, 9'h107, 0, 0, 2'd0);
    vecs[3]  = mk(0, 1, 8'h11, 8'h00, 0, 0, 1, 9'h103, 1, 0, 2'd1);
    vecs[4]  = mk(0, 1, 8'h20, 8'h00, 0, 0, 1, 9'h000, 0, 1, 2'd1);
    vecs[5]  = mk(1, 1, 8'hFF, 8'hA5, 0, 0, 0, 9'h000, 0, 0, 2'd1);
    vecs[6]  = mk(0, 1, 8'hFF, 8'h00, 0, 0, 1, 9'h0A5, 0, 0, 2'd1);
    vecs[7]  = mk(0, 1, 8'hFE, 8'h00, 0, 0, 1, 9'h000, 0, 1, 2'd1);
    vecs[8]  = mk(0, 1, 8'h11, 8'h00, 0, 0, 1, 9'h103, 1, 0, 2'd2);
    vecs[9]  = mk(0, 1, 8'h11, 8'h00, 0, 0, 1, 9'h103, 1, 0, 2'd3);
    vecs[10] = mk(0, 1, 8'h11, 8'h00, 0, 0, 1, 9'h103, 1, 0, 2'd3);
    vecs[11] = mk(0, 1, 8'h11, 8'h00, 0, 0, 1, 9'h103, 1, 0, 2'd3);
    vecs[12] = mk(0, 1, 8'h11, 8'h00, 0, 1, 1, 9'h103, 1, 0, 2'd0);
    vecs[13] = mk(0, 0, 8'h00, 8'h00, 0, 1, 0, 9'h103, 0, 0, 2'd0);
    vecs[14] = mk(1, 0, 8'h01, 8'h80, 0, 0, 0, 9'h103, 0, 0, 2'd0);
    vecs[15] = mk(0, 1, 8'h01, 8'h00, 0, 0, 1, 9'h180, 0, 0, 2'd0);
    vecs[16] = mk(1, 0, 8'h00, 8'hFF, 0, 0, 0, 9'h180, 0, 0, 2'd0);
    vecs[17] = mk(0, 1, 8'h00, 8'h00, 0, 0, 1, 9'h0FF, 0, 0, 2'd0);
    vecs[18] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 9'h0FF, 0, 0, 2'd0);

    rst_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; data_in = '0;
    inj_err = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 9'h000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, vecs[i].inj, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_dout, vecs[i].e_perr,
                 vecs[i].e_uninit, vecs[i].e_cnt);
    end

    // Get non-zero state on every output, then reset asynchronously mid-read.
    drive(1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0);
    check_outs("pre_rst", 1'b1, 9'h103, 1'b1, 1'b0, 2'd1);
    @(negedge clk);
    read = 1'b1; address = 8'h10;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 9'h000, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    check_outs("in_rst", 1'b0, 9'h000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    read = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
      check($sformatf("post_rst_idle%0d.rd_valid", i), 32'(rd_valid), 32'd0);
    end
    drive(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
    check_outs("post_rst_rd", 1'b1, 9'h000, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check_outs("post_rst_idle", 1'b0, 9'h000, 1'b0, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
